pipeline_hazard_controller: RTL and testbench
=============================================

# pipeline_hazard_controller

Issue-control scoreboard for the 5-stage pipeline, sitting between Decode and Execute. Each cycle it decides whether the instruction held in Decode may issue to Execute. It tracks in-flight destination registers to detect RAW/WAW hazards and raises the dependency stall. It also holds Fetch while a PC-changing instruction (BR*, JMP, JSR, JSRR) is unresolved.

## Interface
- Parameters:
  - `NUM_REGS`, 16: architectural registers; register index width is 4.
  - `CNT_WIDTH`, 2: width of each per-register pending counter; saturates at 3.
- Ports:
  - `I_CLOCK` in 1: pipeline clock. All state updates on negedge, matching the pipeline stages.
  - `I_RESET_N` in 1: asynchronous, active-low reset.
  - `I_IssueValid` in 1: Decode holds a valid instruction.
  - `I_Src1Idx` in 4, `I_Src1Used` in 1: source 1 register and whether it is read.
  - `I_Src2Idx` in 4, `I_Src2Used` in 1: source 2 register and whether it is read.
  - `I_DestIdx` in 4, `I_DestWrites` in 1: destination register and whether it is written (JSR/JSRR write R7).
  - `I_IsBranch` in 1: the instruction changes PC.
  - `I_WBValid` in 1, `I_WBDestIdx` in 4: Writeback retires a register write this cycle.
  - `I_BranchResolved` in 1: the Memory stage has delivered the new PC.
  - `O_IssueGrant` out 1: combinational; the instruction advances to Execute this cycle.
  - `O_DepStall` out 1: combinational; Decode must hold.
  - `O_FetchStall` out 1: registered; Fetch must hold.
  - `O_PendingMask` out 16: bit r = (counter[r] != 0), registered.
  - `O_Underflow` out 1: sticky; a retire arrived for a register whose counter was 0.

## Operation
- Scoreboard: 16 counters of `CNT_WIDTH` bits, one per register, counting in-flight writes to that register.
- Effective pending for register r: counter[r] != 0, except when `I_WBValid` && `I_WBDestIdx` == r && counter[r] == 1. In that case r is treated as clear (same-cycle writeback bypass).
- Hazard is true when `I_IssueValid` is high and any of the following holds:
  - `I_Src1Used` and Src1 is effectively pending;
  - `I_Src2Used` and Src2 is effectively pending;
  - `I_DestWrites` and counter[dest] == 3 (saturation). Retire of dest in the same cycle does not relieve this.
- FSM states:
  - RUN (reset state).
  - BR_WAIT: a branch is in flight.
- Grant and stall:
  - `O_IssueGrant` = `I_IssueValid` && state == RUN && !hazard.
  - `O_DepStall` = `I_IssueValid` && !`O_IssueGrant`. This includes every valid instruction presented in BR_WAIT.
- Transitions:
  - RUN to BR_WAIT on `O_IssueGrant` && `I_IsBranch`.
  - BR_WAIT to RUN on `I_BranchResolved`.
  - `I_BranchResolved` in RUN is ignored.
  - Only one branch may be in flight.
- Counter update at each negedge, per register r:
  - inc = grant && `I_DestWrites` && dest == r.
  - dec = `I_WBValid` && `I_WBDestIdx` == r && counter[r] != 0.
  - Next value = counter + inc − dec, so inc and dec together leave the counter unchanged.
- Underflow: `I_WBValid` with counter[`I_WBDestIdx`] == 0 sets `O_Underflow`. Only reset clears it. The counter stays at 0.
- `O_FetchStall` = (state == BR_WAIT), registered.
- Reset (asynchronous, any time, including mid-BR_WAIT):
  - all counters 0, state RUN;
  - `O_FetchStall`, `O_Underflow` = 0; `O_PendingMask` = 16'h0000;
  - `O_IssueGrant` and `O_DepStall` follow their equations. They read 0 when `I_IssueValid` = 0.

## Timing
- Grant and stall are combinational in the same cycle as the Decode inputs, with zero latency.
- The scoreboard increment is visible in `O_PendingMask` and in hazard checks one negedge after the grant.
- `O_FetchStall` rises at the negedge that samples the branch grant. It falls at the negedge that samples `I_BranchResolved`. The earliest re-grant is the cycle after resolution.
- Back-to-back independent instructions issue at 1 per cycle.
- A dependent instruction stalls until the cycle its producer's `I_WBValid` is asserted. It issues in that cycle via the bypass.

## Test plan
- **Reset:** reset mid-BR_WAIT with counter[3] = 2 → `O_FetchStall` = 0, `O_PendingMask` = 0, and the next `I_IssueValid` is granted immediately.
- **RAW with bypass:** grant ADD R1 = R2 + R3, then present ADD R4 = R1 + R1.
  - Required: stall (`O_DepStall` = 1) while bit 1 of `O_PendingMask` is set.
  - Required: grant in the cycle `I_WBValid` = 1 with `I_WBDestIdx` = 1.
- **Saturation:** three grants of MOVI R5 with no retire → counter[5] = 3. A fourth MOVI R5 stalls. One retire of R5 → the fourth is granted next cycle and the counter returns to 3.
- **Simultaneous:** grant writing R6 in the same cycle as a retire of R6 with counter[6] = 1 → counter[6] stays 1 and bit 6 of the mask stays 1.
- **Branch:** grant BRZ → `O_FetchStall` = 1 from the next negedge, and `O_IssueGrant` = 0 even for independent instructions. Pulse `I_BranchResolved` → `O_FetchStall` = 0 and issue resumes. `I_BranchResolved` in RUN → no effect.
- **Underflow:** retire R9 with counter[9] = 0 → `O_Underflow` = 1 and stays 1 until reset; counter[9] stays 0.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//   Issue-control scoreboard between Decode and Execute. Tracks in-flight
//   register writes with per-register saturating counters. It raises a
//   dependency stall on RAW hazards and on counter saturation (WAW). It holds
//   Fetch while a PC-changing instruction is unresolved. All state updates
//   occur on the falling clock edge.
//
// Ports
//   I_CLOCK, I_RESET_N      clock (negedge active), async active-low reset
//   I_IssueValid            Decode holds a valid instruction
//   I_Src1Idx/I_Src1Used    source 1 register / read enable
//   I_Src2Idx/I_Src2Used    source 2 register / read enable
//   I_DestIdx/I_DestWrites  destination register / write enable
//   I_IsBranch              instruction changes PC
//   I_WBValid/I_WBDestIdx   Writeback retires a register write
//   I_BranchResolved        Memory stage delivered the new PC
//   O_IssueGrant            combinational: instruction advances this cycle
//   O_DepStall              combinational: Decode must hold
//   O_FetchStall            registered: Fetch must hold (branch in flight)
//   O_PendingMask           registered: bit r set while counter[r] != 0
//   O_Underflow             sticky: retire seen for a register with no pending write
module pipeline_hazard_controller #(
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned CNT_WIDTH = 2,
    localparam int unsigned IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                I_CLOCK,
    input  logic                I_RESET_N,
    input  logic                I_IssueValid,
    input  logic [IDX_W-1:0]    I_Src1Idx,
    input  logic                I_Src1Used,
    input  logic [IDX_W-1:0]    I_Src2Idx,
    input  logic                I_Src2Used,
    input  logic [IDX_W-1:0]    I_DestIdx,
    input  logic                I_DestWrites,
    input  logic                I_IsBranch,
    input  logic                I_WBValid,
    input  logic [IDX_W-1:0]    I_WBDestIdx,
    input  logic                I_BranchResolved,
    output logic                O_IssueGrant,
    output logic                O_DepStall,
    output logic                O_FetchStall,
    output logic [NUM_REGS-1:0] O_PendingMask,
    output logic                O_Underflow
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {
        RUN,
        BR_WAIT
    } state_e;

    state_e state_q, state_d;

    logic [CNT_WIDTH-1:0] cnt_q [NUM_REGS];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_REGS];

    logic [NUM_REGS-1:0] pend_eff;
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] dec;
    logic [NUM_REGS-1:0] mask_q, mask_d;

    logic fetch_stall_q, fetch_stall_d;
    logic underflow_q, underflow_d;
    logic hazard;
    logic grant;

    // Effective pending: a register whose last in-flight write retires this
    // cycle is treated as clear, letting the consumer issue alongside writeback.
    always_comb begin
        pend_eff = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            pend_eff[r] = (cnt_q[r] != '0) &&
                          !(I_WBValid && (I_WBDestIdx == IDX_W'(r)) && (cnt_q[r] == CNT_ONE));
        end
    end

    // Saturation stall ignores a same-cycle retire of the destination.
    always_comb begin
        hazard = I_IssueValid &&
                 ((I_Src1Used && pend_eff[I_Src1Idx]) ||
                  (I_Src2Used && pend_eff[I_Src2Idx]) ||
                  (I_DestWrites && (cnt_q[I_DestIdx] == CNT_MAX)));
        grant  = I_IssueValid && (state_q == RUN) && !hazard;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (grant && I_IsBranch) state_d = BR_WAIT;
            BR_WAIT: if (I_BranchResolved)    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Grant is blocked at saturation, so the increment can never wrap.
    always_comb begin
        inc    = '0;
        dec    = '0;
        mask_d = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            inc[r]    = grant && I_DestWrites && (I_DestIdx == IDX_W'(r));
            dec[r]    = I_WBValid && (I_WBDestIdx == IDX_W'(r)) && (cnt_q[r] != '0);
            cnt_d[r]  = cnt_q[r] + CNT_WIDTH'(inc[r]) - CNT_WIDTH'(dec[r]);
            mask_d[r] = (cnt_d[r] != '0);
        end
    end

    always_comb begin
        fetch_stall_d = (state_d == BR_WAIT);
        underflow_d   = underflow_q || (I_WBValid && (cnt_q[I_WBDestIdx] == '0));
    end

    always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state_q       <= RUN;
            fetch_stall_q <= 1'b0;
            underflow_q   <= 1'b0;
            mask_q        <= '0;
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            state_q       <= state_d;
            fetch_stall_q <= fetch_stall_d;
            underflow_q   <= underflow_d;
            mask_q        <= mask_d;
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign O_IssueGrant  = grant;
    assign O_DepStall    = I_IssueValid && !grant;
    assign O_FetchStall  = fetch_stall_q;
    assign O_PendingMask = mask_q;
    assign O_Underflow   = underflow_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller
//   Self-checking bench: directed scenarios plus randomized traffic, compared
//   against a behavioural scoreboard model (integer in-flight counts).
module tb_pipeline_hazard_controller;

    logic        I_CLOCK;
    logic        I_RESET_N;
    logic        I_IssueValid;
    logic [3:0]  I_Src1Idx;
    logic        I_Src1Used;
    logic [3:0]  I_Src2Idx;
    logic        I_Src2Used;
    logic [3:0]  I_DestIdx;
    logic        I_DestWrites;
    logic        I_IsBranch;
    logic        I_WBValid;
    logic [3:0]  I_WBDestIdx;
    logic        I_BranchResolved;
    logic        O_IssueGrant;
    logic        O_DepStall;
    logic        O_FetchStall;
    logic [15:0] O_PendingMask;
    logic        O_Underflow;

    pipeline_hazard_controller #(
        .NUM_REGS  (16),
        .CNT_WIDTH (2)
    ) dut (
        .I_CLOCK          (I_CLOCK),
        .I_RESET_N        (I_RESET_N),
        .I_IssueValid     (I_IssueValid),
        .I_Src1Idx        (I_Src1Idx),
        .I_Src1Used       (I_Src1Used),
        .I_Src2Idx        (I_Src2Idx),
        .I_Src2Used       (I_Src2Used),
        .I_DestIdx        (I_DestIdx),
        .I_DestWrites     (I_DestWrites),
        .I_IsBranch       (I_IsBranch),
        .I_WBValid        (I_WBValid),
        .I_WBDestIdx      (I_WBDestIdx),
        .I_BranchResolved (I_BranchResolved),
        .O_IssueGrant     (O_IssueGrant),
        .O_DepStall       (O_DepStall),
        .O_FetchStall     (O_FetchStall),
        .O_PendingMask    (O_PendingMask),
        .O_Underflow      (O_Underflow)
    );

    initial begin
        I_CLOCK = 1'b0;
        forever #5 I_CLOCK = ~I_CLOCK;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: number of in-flight writes per register, branch flag.
    int cnt_m [16];
    bit br_m;
    bit uf_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [15:0] model_mask();
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) m[i] = (cnt_m[i] > 0);
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) cnt_m[i] = 0;
        br_m = 1'b0;
        uf_m = 1'b0;
    endtask

    task automatic clear_inputs();
        I_IssueValid = 0; I_Src1Idx = 0; I_Src1Used = 0; I_Src2Idx = 0; I_Src2Used = 0;
        I_DestIdx = 0; I_DestWrites = 0; I_IsBranch = 0; I_WBValid = 0; I_WBDestIdx = 0;
        I_BranchResolved = 0;
    endtask

    // Asynchronous reset asserted away from the active edge, held across one negedge.
    task automatic do_reset();
        @(posedge I_CLOCK);
        #2;
        clear_inputs();
        I_RESET_N = 1'b0;
        model_reset();
        #1;
        check("rst_fetch", 32'(O_FetchStall), 32'(0));
        check("rst_mask",  32'(O_PendingMask), 32'(0));
        check("rst_uflow", 32'(O_Underflow), 32'(0));
        check("rst_grant", 32'(O_IssueGrant), 32'(0));
        check("rst_stall", 32'(O_DepStall), 32'(0));
        @(posedge I_CLOCK);
        #2;
        I_RESET_N = 1'b1;
    endtask

    // One Decode cycle: drive after posedge, check before the negedge, advance model.
    task automatic step(input bit v, input int s1, input bit s1u, input int s2, input bit s2u,
                        input int d, input bit dw, input bit br,
                        input bit wbv, input int wbd, input bit res);
        bit pend1, pend2, sat, haz, g, st;
        @(posedge I_CLOCK);
        I_IssueValid = v;  I_Src1Idx = 4'(s1); I_Src1Used = s1u;
        I_Src2Idx = 4'(s2); I_Src2Used = s2u;
        I_DestIdx = 4'(d);  I_DestWrites = dw; I_IsBranch = br;
        I_WBValid = wbv;    I_WBDestIdx = 4'(wbd); I_BranchResolved = res;
        #1;
        // A register is blocking unless its only outstanding write retires now.
        pend1 = (cnt_m[s1] > 0) && !(wbv && wbd == s1 && cnt_m[s1] == 1);
        pend2 = (cnt_m[s2] > 0) && !(wbv && wbd == s2 && cnt_m[s2] == 1);
        sat   = (cnt_m[d] >= 3);
        haz   = v && ((s1u && pend1) || (s2u && pend2) || (dw && sat));
        g     = v && !br_m && !haz;
        st    = v && !g;
        check("grant", 32'(O_IssueGrant), 32'(g));
        check("stall", 32'(O_DepStall), 32'(st));
        check("fetch", 32'(O_FetchStall), 32'(br_m));
        check("mask",  32'(O_PendingMask), 32'(model_mask()));
        check("uflow", 32'(O_Underflow), 32'(uf_m));
        if (wbv) begin
            if (cnt_m[wbd] == 0) uf_m = 1'b1;
            else cnt_m[wbd] = cnt_m[wbd] - 1;
        end
        if (g && dw) cnt_m[d] = cnt_m[d] + 1;
        if (br_m) begin
            if (res) br_m = 1'b0;
        end else if (g && br) begin
            br_m = 1'b1;
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic retire(input int r);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, r, 0);
    endtask

    initial begin
        int r;
        clear_inputs();
        I_RESET_N = 1'b0;
        model_reset();
        do_reset();

        // RAW with bypass: R1 = R2 + R3, then R4 = R1 + R1.
        step(1, 2, 1, 3, 1, 1, 1, 0, 0, 0, 0);
        repeat (3) step(1, 1, 1, 1, 1, 4, 1, 0, 0, 0, 0);
        check("raw_mask_bit1", 32'(O_PendingMask[1]), 32'(1));
        check("raw_held", 32'(O_DepStall), 32'(1));
        step(1, 1, 1, 1, 1, 4, 1, 0, 1, 1, 0);
        check("raw_bypass_grant", 32'(O_IssueGrant), 32'(1));
        retire(4);

        // Saturation on R5.
        repeat (3) step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        check("sat_stall", 32'(O_DepStall), 32'(1));
        step(1, 0, 0, 0, 0, 5, 1, 0, 1, 5, 0);
        check("sat_retire_still_stall", 32'(O_DepStall), 32'(1));
        step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        check("sat_regrant", 32'(O_IssueGrant), 32'(1));
        repeat (3) retire(5);

        // Simultaneous issue and retire of R6 at count 1.
        step(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 6, 1, 0, 1, 6, 0);
        idle();
        check("simul_bit6", 32'(O_PendingMask[6]), 32'(1));
        retire(6);

        // Branch hold and resolution; resolution in RUN is ignored.
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        repeat (2) step(1, 8, 1, 0, 0, 10, 1, 0, 0, 0, 0);
        check("br_fetch_hold", 32'(O_FetchStall), 32'(1));
        step(1, 8, 1, 0, 0, 10, 1, 0, 0, 0, 1);
        step(1, 8, 1, 0, 0, 10, 1, 0, 0, 0, 0);
        check("br_resume", 32'(O_IssueGrant), 32'(1));
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        check("br_res_in_run", 32'(O_FetchStall), 32'(0));
        retire(10);

        // Underflow on R9 is sticky.
        retire(9);
        repeat (3) idle();
        check("uflow_sticky", 32'(O_Underflow), 32'(1));
        check("uflow_bit9", 32'(O_PendingMask[9]), 32'(0));

        // Reset in BR_WAIT with counter[3] = 2.
        step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle();
        do_reset();
        step(1, 3, 1, 3, 1, 3, 1, 0, 0, 0, 0);
        check("post_rst_grant", 32'(O_IssueGrant), 32'(1));

        // Randomized traffic over a small register window to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            bit wbv;
            int wbd;
            if (n % 700 == 699) do_reset();
            wbd = $urandom_range(0, 7);
            wbv = 1'b0;
            if (cnt_m[wbd] > 0) wbv = ($urandom_range(0, 1) == 1);
            else if ($urandom_range(0, 99) == 0) wbv = 1'b1;
            r = $urandom_range(0, 7);
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                 r, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0,
                 wbv, wbd,
                 $urandom_range(0, 3) == 0);
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
